// File: rtl/image_loader_pkg.sv
// Shared types and constants for the image loader.
package image_loader_pkg;

    localparam int unsigned NUM_BANKS      = 4;
    localparam int unsigned BANK_SEL_W     = 2;
    localparam int unsigned DEFAULT_ADDR_W = 10;
    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned PIX_CNT_W      = 13;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2,
        StFull  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/image_bank_writer.sv
// Registered write stage: turns an accepted pixel and its frame index into a
// one-hot bank write enable, a bank address and the replicated pixel byte,
// all presented one cycle after the accept.
module image_bank_writer
    import image_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         accept_i,
    input  logic [ADDR_W+BANK_SEL_W-1:0] index_i,
    input  logic [DATA_W-1:0]            pixel_i,
    output logic [NUM_BANKS-1:0]         we_o,
    output logic [ADDR_W-1:0]            addr_o,
    output logic [DATA_W-1:0]            data_o
);

    logic [NUM_BANKS-1:0] we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;

    // Decode the low index bits into the bank strobe; upper bits are the address.
    always_comb begin
        we_d   = '0;
        addr_d = addr_q;
        data_d = data_q;
        if (accept_i) begin
            we_d[index_i[BANK_SEL_W-1:0]] = 1'b1;
            addr_d = index_i[ADDR_W+BANK_SEL_W-1:BANK_SEL_W];
            data_d = pixel_i;
        end
    end

    // Write stage register; reset drops any pending write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/image_loader.sv
// Frame loader: accepts a pixel stream under valid/ready, stripes pixels
// round-robin across four image banks and holds the frame until released.
// Optional frame checksum is enabled with IMAGE_LOADER_CHECKSUM_EN.
module image_loader
    import image_loader_pkg::*;
#(
    parameter int unsigned NUM_PIX = 4096,
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W  = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_W-1:0]    pix_data,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [ADDR_W-1:0]    image_ram_addr_b,
    output logic [DATA_W-1:0]    data_image_0,
    output logic [DATA_W-1:0]    data_image_1,
    output logic [DATA_W-1:0]    data_image_2,
    output logic [DATA_W-1:0]    data_image_3,
    output logic                 we_image0,
    output logic                 we_image1,
    output logic                 we_image2,
    output logic                 we_image3,
    output logic                 img_valid,
    input  logic                 img_release,
    output logic [PIX_CNT_W-1:0] pix_count,
    output logic                 err_start,
    output logic [DATA_W-1:0]    checksum
);

    localparam int unsigned IDX_W = ADDR_W + BANK_SEL_W;
    localparam logic [PIX_CNT_W-1:0] LastIdx = PIX_CNT_W'(NUM_PIX - 1);
    localparam logic [PIX_CNT_W-1:0] MaxCnt  = PIX_CNT_W'(NUM_PIX);

    loader_state_t        state_q, state_d;
    logic [PIX_CNT_W-1:0] pix_count_q, pix_count_d;
    logic                 err_start_q, err_start_d;
    logic                 accept;
    logic                 clear_frame;
    logic [NUM_BANKS-1:0] we;
    logic [DATA_W-1:0]    wr_data;

    // Ready depends on state only so upstream valid never loops back into ready.
    assign pix_ready = (state_q == StLoad);
    assign img_valid = (state_q == StFull);
    assign accept    = pix_ready & pix_valid;

    // Next-state logic; start while busy is flagged unless paired with release in FULL.
    always_comb begin
        state_d     = state_q;
        err_start_d = err_start_q;
        clear_frame = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    clear_frame = 1'b1;
                end
            end
            StLoad: begin
                if (start) err_start_d = 1'b1;
                if (accept && (pix_count_q == LastIdx)) state_d = StFlush;
            end
            StFlush: begin
                if (start) err_start_d = 1'b1;
                state_d = StFull;
            end
            StFull: begin
                if (img_release) begin
                    clear_frame = start;
                    state_d     = start ? StLoad : StIdle;
                end else if (start) begin
                    err_start_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Accepted-pixel counter, saturating at one full frame.
    always_comb begin
        pix_count_d = pix_count_q;
        if (clear_frame) begin
            pix_count_d = '0;
        end else if (accept && (pix_count_q < MaxCnt)) begin
            pix_count_d = pix_count_q + 1'b1;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            pix_count_q <= '0;
            err_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_count_q <= pix_count_d;
            err_start_q <= err_start_d;
        end
    end

    assign pix_count = pix_count_q;
    assign err_start = err_start_q;

    image_bank_writer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_writer (
        .clk_i    (clk),
        .rst_ni   (reset),
        .accept_i (accept),
        .index_i  (IDX_W'(pix_count_q)),
        .pixel_i  (pix_data),
        .we_o     (we),
        .addr_o   (image_ram_addr_b),
        .data_o   (wr_data)
    );

    assign we_image0    = we[0];
    assign we_image1    = we[1];
    assign we_image2    = we[2];
    assign we_image3    = we[3];
    assign data_image_0 = wr_data;
    assign data_image_1 = wr_data;
    assign data_image_2 = wr_data;
    assign data_image_3 = wr_data;

`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    // Running byte sum of the current frame, wrapping mod 2^DATA_W.
    always_comb begin
        sum_d = sum_q;
        if (clear_frame) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + pix_data;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: randomized pixel stream, scoreboard of expected bank
// writes derived from the frame index, and a shadow copy of the four banks.
module tb_image_loader;
    import image_loader_pkg::*;

    localparam int unsigned NUM_PIX = 4096;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = NUM_PIX / 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [DATA_W-1:0]    pix_data = '0;
    logic                 pix_valid = 1'b0;
    logic                 img_release = 1'b0;
    logic                 pix_ready;
    logic [ADDR_W-1:0]    image_ram_addr_b;
    logic [DATA_W-1:0]    data_image_0, data_image_1, data_image_2, data_image_3;
    logic                 we_image0, we_image1, we_image2, we_image3;
    logic                 img_valid;
    logic [PIX_CNT_W-1:0] pix_count;
    logic                 err_start;
    logic [DATA_W-1:0]    checksum;

    image_loader #(
        .NUM_PIX (NUM_PIX),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .image_ram_addr_b (image_ram_addr_b),
        .data_image_0     (data_image_0),
        .data_image_1     (data_image_1),
        .data_image_2     (data_image_2),
        .data_image_3     (data_image_3),
        .we_image0        (we_image0),
        .we_image1        (we_image1),
        .we_image2        (we_image2),
        .we_image3        (we_image3),
        .img_valid        (img_valid),
        .img_release      (img_release),
        .pix_count        (pix_count),
        .err_start        (err_start),
        .checksum         (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        bank;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] mem [4][DEPTH];
    int                n_cmp = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] sum_model;
    bit                err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every bank write the DUT presents is popped against the scoreboard.
    always @(negedge clk) begin
        logic [3:0] we;
        int         b;
        wr_t        e;
        we = {we_image3, we_image2, we_image1, we_image0};
        if (we != 4'b0) begin
            check("we_onehot", 32'($onehot(we)), 32'd1);
            b = we[0] ? 0 : we[1] ? 1 : we[2] ? 2 : 3;
            mem[b][image_ram_addr_b] = data_image_0;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_bank", 32'(b), 32'(e.bank));
                check("wr_addr", 32'(image_ram_addr_b), 32'(e.addr));
                check("wr_data", {data_image_3, data_image_2, data_image_1, data_image_0},
                      {4{e.data}});
            end
        end
    end

    function automatic logic [DATA_W-1:0] exp_checksum(input logic [DATA_W-1:0] s);
`ifdef IMAGE_LOADER_CHECKSUM_EN
        return s;
`else
        return '0;
`endif
    endfunction

    task automatic check_reset_outputs();
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_addr", 32'(image_ram_addr_b), 0);
        check("rst_data", {data_image_3, data_image_2, data_image_1, data_image_0}, 0);
        check("rst_we", 32'({we_image3, we_image2, we_image1, we_image0}), 0);
        check("rst_img_valid", 32'(img_valid), 0);
        check("rst_pix_count", 32'(pix_count), 0);
        check("rst_err_start", 32'(err_start), 0);
        check("rst_checksum", 32'(checksum), 0);
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_pix_ready", 32'(pix_ready), 1);
        check("start_pix_count", 32'(pix_count), 0);
        check("start_img_valid", 32'(img_valid), 0);
    endtask

    // mode: 0 = k mod 256, 1 = random bytes, 2 = all 0x01.
    task automatic load_frame(input int mode, input bit gaps, input int err_at, input int abort_at);
        int  idx = 0;
        int  cyc = 0;
        bit  err_done = 1'b0;
        wr_t e;
        sum_model = '0;
        while (idx < int'(NUM_PIX)) begin
            @(posedge clk); #1;
            if (idx == abort_at) begin
                reset = 1'b0;
                pix_valid = 1'b0;
                start = 1'b0;
                @(posedge clk); #1;
                @(negedge clk);
                check_reset_outputs();
                check("abort_queue_empty", 32'(exp_q.size()), 0);
                reset = 1'b1;
                err_exp = 1'b0;
                return;
            end
            pix_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            pix_data  = (mode == 0) ? 8'(idx) : (mode == 1) ? 8'($urandom) : 8'h01;
            start     = 1'b0;
            if (idx == err_at && !err_done) begin
                start    = 1'b1;
                err_done = 1'b1;
                err_exp  = 1'b1;
            end
            @(negedge clk);
            check("load_pix_ready", 32'(pix_ready), 1);
            if (pix_valid) begin
                e.bank = 2'(idx % 4);
                e.addr = ADDR_W'(idx / 4);
                e.data = pix_data;
                exp_q.push_back(e);
                sum_model = sum_model + pix_data;
                idx++;
            end
            cyc++;
            if (cyc > 8 * int'(NUM_PIX)) begin
                check("load_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush_img_valid", 32'(img_valid), 0);
        check("flush_pix_ready", 32'(pix_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_img_valid", 32'(img_valid), 1);
        check("full_pix_ready", 32'(pix_ready), 0);
        check("full_pix_count", 32'(pix_count), NUM_PIX);
        check("full_err_start", 32'(err_start), 32'(err_exp));
        check("full_checksum", 32'(checksum), 32'(exp_checksum(sum_model)));
        check("full_queue_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic release_frame(input bit with_start);
        @(posedge clk); #1;
        img_release = 1'b1;
        start = with_start;
        @(negedge clk);
        check("rel_img_valid_hold", 32'(img_valid), 1);
        @(posedge clk); #1;
        img_release = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rel_img_valid", 32'(img_valid), 0);
        check("rel_pix_ready", 32'(pix_ready), 32'(with_start));
        check("rel_err_start", 32'(err_start), 32'(err_exp));
        if (with_start) check("rel_pix_count", 32'(pix_count), 0);
    endtask

    task automatic clear_mem();
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < int'(DEPTH); a++) mem[b][a] = 'x;
    endtask

    task automatic check_ramp_mem(input string name);
        int bad = 0;
        for (int k = 0; k < int'(NUM_PIX); k++)
            if (mem[k % 4][k / 4] !== 8'(k)) bad++;
        check(name, 32'(bad), 0);
    endtask

    initial begin
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        // Back-to-back ramp frame.
        start_frame();
        load_frame(0, 1'b0, -1, -1);
        check("bank1_addr1", 32'(mem[1][1]), 32'd5);
        check("bank3_addr1023", 32'(mem[3][1023]), 32'd255);
        check_ramp_mem("ramp_contents");

        // Release together with start, then same ramp with random gaps.
        clear_mem();
        release_frame(1'b1);
        load_frame(0, 1'b1, -1, -1);
        check_ramp_mem("gap_contents");

        // Stray start mid-load and in FULL.
        release_frame(1'b0);
        start_frame();
        load_frame(1, 1'b1, 100, -1);
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("full_start_ignored", 32'(img_valid), 1);
        check("full_start_err", 32'(err_start), 1);

        // Reset mid-frame, then a fresh all-ones frame from index 0.
        release_frame(1'b0);
        start_frame();
        load_frame(1, 1'b0, -1, 2000);
        start_frame();
        load_frame(2, 1'b0, -1, -1);
        check("ones_bank0_addr0", 32'(mem[0][0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/image_loader.md
# image_loader

Upstream fill stage for the four image RAM banks of the memory block. Accepts a byte-wide pixel stream from the host-side bridge under valid/ready, stripes pixels round-robin across banks 0..3 through the memory block's image write port (`b` port), and raises `img_valid` once a full frame is resident. The frame stays locked until the convolution stage releases it.

## Interface
Parameters:
- `NUM_PIX`, 4096: pixels per frame; multiple of 4, max 4096.
- `ADDR_W`, 10: image bank address width.
- `DATA_W`, 8: pixel width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a frame load.
- `pix_data`  in  DATA_W  pixel byte.
- `pix_valid`  in  1  `pix_data` valid.
- `pix_ready`  out  1  loader accepts pixel this cycle.
- `image_ram_addr_b`  out  ADDR_W  bank write address.
- `data_image_0..3`  out  DATA_W  bank write data; all four carry the same byte.
- `we_image0..3`  out  1  bank write enables, at most one high.
- `img_valid`  out  1  full frame resident in banks.
- `img_release`  in  1  consumer done with frame.
- `pix_count`  out  13  pixels accepted in current frame.
- `err_start`  out  1  sticky: `start` seen while busy.
- `checksum`  out  DATA_W  frame byte sum (see Configuration).

## Operation
- States: IDLE, LOAD, FLUSH, FULL.
- Reset (`reset`=0 at a clock edge): state IDLE; all outputs 0; `pix_count` 0; pending write dropped. Applies mid-frame; a partial frame is discarded and banks are not cleared.
- IDLE: `pix_ready`=0. On `start`, go to LOAD and clear `pix_count`/checksum.
- LOAD: `pix_ready`=1 (combinational from state only, never from `pix_valid`). Accept when `pix_valid & pix_ready`. Pixel index k goes to bank k[1:0] at address k[ADDR_W+1:2]. `pix_count` increments on accept. Accepting index NUM_PIX-1 moves to FLUSH.
- FLUSH: `pix_ready`=0. The final pending write is issued. Next state is FULL.
- FULL: `img_valid`=1 and `pix_ready`=0. `img_release` returns to IDLE. `img_release` and `start` in the same cycle go directly to LOAD, counters cleared, with no error.
- `start` in LOAD, FLUSH, or FULL without `img_release` is ignored and sets `err_start`. Only reset clears it.
- Pixels presented outside LOAD are not consumed. The upstream holds them.
- `pix_count` saturates at NUM_PIX. Index arithmetic is unsigned with no wrap within a frame.

## Timing
- Write latency is 1: a pixel accepted at edge t drives `we_imageN`/addr/data during cycle t+1 and commits to the RAM at edge t+2.
- Full-rate: one pixel per cycle sustained in LOAD, no bubbles.
- `img_valid` rises 2 cycles after the last accept. All banks are readable from that cycle.
- `img_valid` falls the cycle after the `img_release` edge.
- Minimum frame period is NUM_PIX+3 cycles.

## Configuration
- `IMAGE_LOADER_CHECKSUM_EN` defined:
  - `checksum` = sum mod 256 of accepted pixels.
  - Cleared on frame start and updated on each accept.
  - Stable in FULL.
- Not defined: `checksum` is tied to 0 and the accumulator is not synthesized. The port list is unchanged.

## Structure
- Package `image_loader_pkg`:
  - state enum `loader_state_t`.
  - `NUM_BANKS`=4, `BANK_SEL_W`=2, default `ADDR_W`/`DATA_W`.
  - `PIX_CNT_W`=13.
- Sub-module `image_bank_writer`: registered write stage. Takes accept, index, and pixel; produces the one-hot `we_image0..3`, the address, and the replicated data one cycle later. It is flushed by reset.

## Test plan
- Reset, `start`, then 4096 back-to-back pixels with value k mod 256:
  - pixel 5 lands in bank 1 at address 1, pixel 4095 in bank 3 at address 1023.
  - `img_valid` rises exactly 2 cycles after the last accept.
- Random `pix_valid` gaps (~50%): bank contents identical to the gap-free run; `pix_count`=4096 at FULL.
- `start` mid-LOAD at pixel 100: `err_start`=1, load continues, frame completes normally.
- `reset` low at pixel 2000: next cycle all outputs 0 and state IDLE. A new `start` reloads from index 0.
- In FULL, `img_release` and `start` together: `img_valid`=0 next cycle, `pix_ready`=1, `err_start` stays 0.
- With `IMAGE_LOADER_CHECKSUM_EN`, frame of all 0x01: `checksum`=0x00 (4096 mod 256). Without it, `checksum`=0 throughout.
